// File: rtl/receive_data_if.sv
// Bus between the UART byte source and the frame receiver: byte strobe in,
// accepted-frame data, status pulses, counters and FSM debug state out.
interface receive_data_if;
    // data_ready is a valid-only strobe. Each cycle it is high, data_receive
    // carries one new byte that is consumed on that edge. There is no ready,
    // so the receiver can never apply backpressure.
    logic       data_ready;
    logic [7:0] data_receive;
    logic [7:0] data_feedback;
    logic [7:0] data_channel;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] err_count;
    logic [7:0] led;
    logic [1:0] dbg_state;

    modport master (
        output data_ready, data_receive,
        input  data_feedback, data_channel, frame_valid, frame_err,
        input  err_count, led, dbg_state
    );

    modport slave (
        input  data_ready, data_receive,
        output data_feedback, data_channel, frame_valid, frame_err,
        output err_count, led, dbg_state
    );
endinterface

// File: rtl/receive_data.sv
// Frame receiver for HEADER, feedback, channel, checksum (feedback ^ channel).
// It has an inter-byte idle timeout and counts good frames and dropped frames.
module receive_data #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1000
) (
    input  logic          uart_clk,
    input  logic          rst_n,
    receive_data_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FB = 2'd1,
        WAIT_CH = 2'd2,
        WAIT_CK = 2'd3
    } state_t;

    localparam int            GW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_fb_shadow;
    logic [7:0]    r_ch_shadow;
    logic [7:0]    r_data_feedback;
    logic [7:0]    r_data_channel;
    logic          r_frame_valid;
    logic          r_frame_err;
    logic [3:0]    r_good_count;
    logic [7:0]    r_err_count;

    logic          w_gap_hit;
    logic          w_load_fb;
    logic          w_load_ch;
    logic          w_accept;
    logic          w_reject;
    logic          w_timeout;

    // A byte arriving on the expiry cycle takes priority because every state
    // tests data_ready before it tests w_gap_hit.
    assign w_gap_hit = (r_gap == GAP_MAX);

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load_fb = 1'b0;
        w_load_ch = 1'b0;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.data_ready && (bus.data_receive == HEADER)) begin
                    w_next = WAIT_FB;
                end
            end
            WAIT_FB: begin
                if (bus.data_ready) begin
                    w_load_fb = 1'b1;
                    w_next    = WAIT_CH;
                end else if (w_gap_hit) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            WAIT_CH: begin
                if (bus.data_ready) begin
                    w_load_ch = 1'b1;
                    w_next    = WAIT_CK;
                end else if (w_gap_hit) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            WAIT_CK: begin
                if (bus.data_ready) begin
                    if (bus.data_receive == (r_fb_shadow ^ r_ch_shadow)) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                    w_next = IDLE;
                end else if (w_gap_hit) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Payload bytes go to the shadows first. The visible outputs change only
    // when a whole frame checks out.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_gap           <= '0;
            r_fb_shadow     <= 8'h00;
            r_ch_shadow     <= 8'h00;
            r_data_feedback <= 8'h00;
            r_data_channel  <= 8'h00;
            r_frame_valid   <= 1'b0;
            r_frame_err     <= 1'b0;
            r_good_count    <= 4'h0;
            r_err_count     <= 8'h00;
        end else begin
            r_frame_valid <= w_accept;
            r_frame_err   <= w_reject | w_timeout;

            if (w_load_fb) begin
                r_fb_shadow <= bus.data_receive;
            end
            if (w_load_ch) begin
                r_ch_shadow <= bus.data_receive;
            end

            if (w_accept) begin
                r_data_feedback <= r_fb_shadow;
                r_data_channel  <= r_ch_shadow;
                r_good_count    <= r_good_count + 4'd1;
            end

            if ((w_reject || w_timeout) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            if (bus.data_ready || (r_state == IDLE) || w_gap_hit) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign bus.data_feedback = r_data_feedback;
    assign bus.data_channel  = r_data_channel;
    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_err     = r_frame_err;
    assign bus.err_count     = r_err_count;
    assign bus.led           = {r_good_count, r_err_count[3:0]};
    assign bus.dbg_state     = r_state;

endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, meaning the maximum idle cycles allowed between bytes within a frame.
REQ-003 Port uart_clk, input, 1, SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port data_ready, input, 1, SHALL be a one-cycle strobe marking a new byte on data_receive.
REQ-006 Port data_receive, input, 8, SHALL be the byte from the UART receiver, valid only when data_ready=1.
REQ-007 Port data_feedback, output, 8, SHALL carry the last accepted feedback byte.
REQ-008 Port data_channel, output, 8, SHALL carry the last accepted channel byte.
REQ-009 Port frame_valid, output, 1, SHALL give a one-cycle pulse when a frame is accepted.
REQ-010 Port frame_err, output, 1, SHALL give a one-cycle pulse when a frame is dropped.
REQ-011 Port err_count, output, 8, SHALL be a saturating count of dropped frames.
REQ-012 Port led, output, 8, SHALL be the debug indicator {good_count[3:0], err_count[3:0]}.

Function
REQ-013 The frame format SHALL be HEADER, feedback, channel, checksum, where checksum = feedback XOR channel.
REQ-014 The FSM SHALL have four states: IDLE, WAIT_FB, WAIT_CH, WAIT_CK.
REQ-015 In IDLE, a byte equal to HEADER SHALL cause a transition to WAIT_FB; any other byte, including 0x00 filler, SHALL be ignored silently.
REQ-016 A byte received in WAIT_FB SHALL be stored in a shadow register, and the FSM SHALL go to WAIT_CH.
REQ-017 A byte received in WAIT_CH SHALL be stored in a shadow register, and the FSM SHALL go to WAIT_CK.
REQ-018 When the checksum byte in WAIT_CK matches, the block SHALL, on the next edge: copy the shadows to data_feedback/data_channel, pulse frame_valid, increment the 4-bit good_count (wrapping), and go to IDLE.
REQ-019 When the checksum byte in WAIT_CK mismatches, the block SHALL: leave data_feedback/data_channel unchanged, pulse frame_err, increment err_count (saturating at 255), and go to IDLE.
REQ-020 A HEADER-valued byte received in WAIT_FB, WAIT_CH or WAIT_CK SHALL be treated as ordinary payload; there is no mid-frame resync.
REQ-021 The gap counter SHALL clear on every data_ready, count only outside IDLE, and hold at 0 in IDLE.
REQ-022 When the gap counter reaches TIMEOUT-1 with no data_ready, the FSM SHALL go to IDLE, pulse frame_err, and increment err_count; the outputs hold.
REQ-023 When data_ready and the timeout occur in the same cycle, the byte SHALL win and no timeout SHALL occur.
REQ-024 The latency SHALL be exactly 1 cycle from the checksum-byte strobe to frame_valid/frame_err, and from the output update to visibility on the registered outputs.
REQ-025 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-026 Back-to-back frames SHALL be accepted: a HEADER in the cycle after the checksum strobe starts the new frame.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, and clear to 0 the shadows, gap counter, good_count, err_count, data_feedback, data_channel, frame_valid, frame_err and led.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.
REQ-030 data_ready during reset SHALL be ignored.

Verification
REQ-031 Stimulus A5,12,34,26 -> the response SHALL be one frame_valid pulse one cycle after 26, data_feedback=0x12, data_channel=0x34, led=0x10.
REQ-032 Stimulus A5,12,34,27 -> the response SHALL be a frame_err pulse, err_count=1, data outputs unchanged from the prior value.
REQ-033 Stimulus A5,12 then TIMEOUT idle cycles -> the response SHALL be a frame_err pulse at gap TIMEOUT-1, state IDLE; a following full valid frame SHALL then be accepted.
REQ-034 Stimulus 00,00,A5,A5,A5,00 -> the response SHALL be frame_valid with data_feedback=0xA5, data_channel=0xA5 (checksum 0x00), with no error from the leading filler bytes.
REQ-035 Stimulus of 300 bad-checksum frames -> err_count SHALL saturate at 255 and led[3:0] SHALL equal 0xF.
REQ-036 Stimulus A5,12 then rst_n low for 1 cycle, then A5,01,02,03 -> the response SHALL be no frame_err pulse and a frame_valid pulse with data_feedback=0x01, data_channel=0x02.
